apb_arb_master: RTL
===================

Name: apb_arb_master

Overview:
- Shares one APB slave (10-bit address, 32-bit data) between NUM_REQ local requesters.
- Round-robin arbitration selects a requester; the block then sequences a full APB SETUP/ACCESS transfer and returns completion and read data to the winner.
- Sits between requester logic and the existing APB register slave; it is the only APB master on that bus.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit; used only with APB_TIMEOUT_EN.

Ports:
- clk  input  1  clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req_i  input  NUM_REQ  per-requester transfer request; held until matching done_o.
- req_write_i  input  NUM_REQ  per-requester direction; 1 = write, 0 = read.
- req_addr_i  input  NUM_REQ x 10  per-requester address.
- req_wdata_i  input  NUM_REQ x 32  per-requester write data.
- done_o  output  NUM_REQ  one-cycle completion pulse, one-hot.
- rdata_o  output  32  read data; valid in the done_o cycle.
- err_o  output  1  timeout error flag; valid in the done_o cycle.
- psel_o  output  1  APB select.
- penable_o  output  1  APB enable.
- paddr_o  output  10  APB address.
- pwrite_o  output  1  APB direction.
- pwdata_o  output  32  APB write data.
- prdata_i  input  32  APB read data.
- pready_i  input  1  APB ready.

Behaviour:
- Reset (synchronous): state = ST_IDLE; rr_ptr = 0.
  - Zeroed outputs: psel_o, penable_o, paddr_o, pwrite_o, pwdata_o, done_o, rdata_o, err_o.
  - Reset mid-transfer: the bus is dropped at the next edge; no done_o is issued.
- ST_IDLE:
  - psel_o = 0, penable_o = 0.
  - If any req_i bit is set, grant the first set bit searching from rr_ptr upward with wrap.
  - At the same edge, latch the winner's addr/write/wdata into paddr_o/pwrite_o/pwdata_o, record the winner index, and go to ST_SETUP.
- ST_SETUP: psel_o = 1, penable_o = 0; unconditionally go to ST_ACCESS next cycle.
- ST_ACCESS: psel_o = 1, penable_o = 1; hold until pready_i = 1.
- Completion cycle (edge where pready_i is sampled high in ST_ACCESS):
  - Register done_o[winner] = 1 for exactly one cycle.
  - rdata_o = prdata_i for a read; rdata_o is unchanged for a write.
  - err_o = 0.
  - rr_ptr = (winner + 1) mod NUM_REQ.
  - Return to ST_IDLE; psel_o/penable_o are low in the done_o cycle.
- Timing:
  - Minimum latency from req_i (seen in IDLE) to done_o is 3 cycles with zero-wait pready_i.
  - There is always one IDLE cycle between transfers.
  - The requester drops req_i the cycle after done_o. The IDLE cycle must re-arbitrate, so a requester holding req_i can be re-granted only through normal round-robin order.
- Payload is latched at grant; APB outputs are stable throughout SETUP/ACCESS regardless of requester input changes.
- req_i withdrawn before done_o: this is a protocol violation by the requester. The transfer still completes and done_o still pulses.
- Simultaneous requests: strict round-robin. The requester just served has the lowest priority on the next arbitration.
- paddr_o, pwrite_o and pwdata_o hold their last values in IDLE.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter clears on entry to ST_ACCESS and increments each cycle pready_i = 0.
  - When it reaches TIMEOUT_CYCLES, the transfer aborts.
  - Abort response: done_o[winner] = 1, err_o = 1, rdata_o = 32'hDEAD_BEEF, rr_ptr advances, go to ST_IDLE.
- APB_TIMEOUT_EN undefined: no counter is built; ACCESS waits indefinitely; err_o is tied 0.

Decomposition:
- Package apb_pkg:
  - APB_ADDR_W = 10, APB_DATA_W = 32.
  - typedef enum apb_state_e {ST_IDLE, ST_SETUP, ST_ACCESS}.
  - typedef struct apb_req_t {write, addr, wdata}.
- Sub-module rr_arbiter:
  - Combinational.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant and grant index.
  - NUM_REQ parameterised.

Test Plan:
- Single write then read: req0 write addr 0x155 data 0x1234_5678, then read 0x155 -> psel/penable sequence IDLE/SETUP/ACCESS; done_o[0] after 3 cycles; rdata_o = 0x1234_5678.
- Wait states: slave holds pready_i = 0 for 4 ACCESS cycles -> penable_o high for 5 cycles; APB outputs stable; single done_o pulse.
- Contention: req0 and req1 asserted together and held continuously -> grants alternate 0,1,0,1 over 4 transfers, starting at 0 after reset.
- Payload stability: req1 changes req_addr_i from 0x010 to 0x3FF during SETUP -> paddr_o stays 0x010 until done_o.
- Reset in ST_ACCESS: assert reset for 1 cycle -> psel_o = penable_o = 0 at the next edge; no done_o; next grant goes to req0.
- APB_TIMEOUT_EN with pready_i held 0 -> after 16 ACCESS cycles: done_o, err_o = 1, rdata_o = 0xDEAD_BEEF; the next requester is served normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared APB bus widths, master FSM states and the latched request payload type.
package apb_pkg;

    localparam int APB_ADDR_W = 10;
    localparam int APB_DATA_W = 32;

    // Read data returned on an ACCESS-phase timeout abort.
    localparam logic [APB_DATA_W-1:0] APB_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above
// i_rr_ptr, wrapping around, as both a one-hot vector and an index.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx
);

    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_cand      = '0;
        w_found     = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_W'((32'(i_rr_ptr) + k) % NUM_REQ);
            if (!w_found && i_req[w_cand]) begin
                w_found          = 1'b1;
                o_grant[w_cand]  = 1'b1;
                o_grant_idx      = w_cand;
            end
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Round-robin arbitrated APB master sharing one slave between NUM_REQ requesters.
// Define APB_TIMEOUT_EN to build the ACCESS-phase timeout (err_o, DEAD_BEEF response).
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_i,
    input  logic [NUM_REQ-1:0]                    req_write_i,
    input  logic [NUM_REQ-1:0][APB_ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_REQ-1:0][APB_DATA_W-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]                    done_o,
    output logic [APB_DATA_W-1:0]                 rdata_o,
    output logic                                  err_o,
    output logic                                  psel_o,
    output logic                                  penable_o,
    output logic [APB_ADDR_W-1:0]                 paddr_o,
    output logic                                  pwrite_o,
    output logic [APB_DATA_W-1:0]                 pwdata_o,
    input  logic [APB_DATA_W-1:0]                 prdata_i,
    input  logic                                  pready_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    generate
        if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
            $error("apb_arb_master: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
        end
    endgenerate

    apb_state_e           r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_rr_ptr, r_winner, w_grant_idx;
    logic [NUM_REQ-1:0]   w_grant, r_done;
    logic [APB_DATA_W-1:0] r_rdata;
    apb_req_t             r_req, w_win_req;
    logic                 w_any, w_complete, w_abort;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .i_req       (req_i),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign w_any           = |w_grant;
    assign w_win_req.write = req_write_i[w_grant_idx];
    assign w_win_req.addr  = req_addr_i[w_grant_idx];
    assign w_win_req.wdata = req_wdata_i[w_grant_idx];

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_err;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            ST_IDLE:   if (w_any) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (pready_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`ifdef APB_TIMEOUT_EN
                // Abort on the cycle that would make the wait count reach the limit.
                else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= '0;
            r_winner <= '0;
            r_req    <= '0;
            r_done   <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= '0;
            if (r_state == ST_IDLE && w_any) begin
                r_req    <= w_win_req;
                r_winner <= w_grant_idx;
            end
            if (w_complete || w_abort) begin
                r_done[r_winner] <= 1'b1;
                r_rr_ptr <= (r_winner == IDX_W'(NUM_REQ - 1)) ? '0 : r_winner + 1'b1;
                if (w_abort)
                    r_rdata <= APB_TIMEOUT_RDATA;
                else if (!r_req.write)
                    r_rdata <= prdata_i;
            end
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state != ST_ACCESS)
                r_tmo_cnt <= '0;
            else if (!pready_i)
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            if (w_complete || w_abort)
                r_err <= w_abort;
        end
    end
    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign psel_o    = (r_state != ST_IDLE);
    assign penable_o = (r_state == ST_ACCESS);
    assign paddr_o   = r_req.addr;
    assign pwrite_o  = r_req.write;
    assign pwdata_o  = r_req.wdata;
    assign done_o    = r_done;
    assign rdata_o   = r_rdata;

endmodule
